// File: rtl/ide_sector_loader.sv
// Sector-fill engine: streams bytes into the IDE data buffer, then
// programs iopos, iotarget and iocontrol so the host can read them.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a transfer (sampled in IDLE only)
//   byte_count      bytes to load (even, 2..512)
//   ctrl_value      value written to iocontrol at the end
//   busy/done/err   status: not idle / completion pulse / bad count
//   s_data/s_valid  upstream byte stream, s_ready accepts a byte
//   cpu_*           AVR SRAM-style bus (passed through while idle)
//   ide_*           IDE register/buffer port
module ide_sector_loader #(
  parameter logic [9:0] BUF_BASE      = 10'h200,
  parameter logic [9:0] REG_IOCONTROL = 10'h002,
  parameter logic [9:0] REG_IOPOS     = 10'h003,
  parameter logic [9:0] REG_IOTARGET  = 10'h005
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] byte_count,
  input  logic [7:0] ctrl_value,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [9:0] cpu_a,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out,
  input  logic       cpu_cs,
  input  logic       cpu_oe,
  input  logic       cpu_we,
  output logic       cpu_wait,
  output logic [9:0] ide_a,
  output logic [7:0] ide_d_out,
  input  logic [7:0] ide_d_in,
  output logic       ide_cs,
  output logic       ide_oe,
  output logic       ide_we,
  input  logic       ide_wait
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SET_POS,
    SET_TGT,
    SET_CTRL,
    DONE
  } state_t;

  state_t     state;
  logic [9:0] idx;
  logic [9:0] count;
  logic [7:0] ctrl;

  logic       count_ok;
  logic       take;
  logic       last;
  logic [7:0] tgt;

  assign count_ok = ~byte_count[0]
                  && (byte_count != 10'd0)
                  && (byte_count <= 10'd512);

  assign take = (state == LOAD) && s_valid && !ide_wait;
  assign last = (idx == count - 10'd1);

  // Word count minus one; 512 wraps 0-1 to 255 in 8 bits.
  assign tgt = count[8:1] - 8'd1;

  assign cpu_d_out = ide_d_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      idx   <= '0;
      count <= '0;
      ctrl  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count <= byte_count;
            ctrl  <= ctrl_value;
            idx   <= '0;
            err   <= !count_ok;
            if (count_ok) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (take) begin
            if (last) state <= SET_POS;
            else      idx   <= idx + 10'd1;
          end
        end
        SET_POS: begin
          if (!ide_wait) state <= SET_TGT;
        end
        SET_TGT: begin
          if (!ide_wait) state <= SET_CTRL;
        end
        SET_CTRL: begin
          if (!ide_wait) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ide_a     = cpu_a;
    ide_d_out = cpu_d_in;
    ide_cs    = 1'b0;
    ide_oe    = 1'b0;
    ide_we    = 1'b0;
    cpu_wait  = cpu_cs;
    s_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        ide_cs   = cpu_cs;
        ide_oe   = cpu_oe;
        ide_we   = cpu_we;
        cpu_wait = ide_wait;
      end
      LOAD: begin
        s_ready   = ~ide_wait;
        ide_a     = BUF_BASE + idx;
        ide_d_out = s_data;
        ide_cs    = take;
        ide_we    = take;
      end
      SET_POS: begin
        ide_a     = REG_IOPOS;
        ide_d_out = 8'h00;
        ide_cs    = 1'b1;
        ide_we    = 1'b1;
      end
      SET_TGT: begin
        ide_a     = REG_IOTARGET;
        ide_d_out = tgt;
        ide_cs    = 1'b1;
        ide_we    = 1'b1;
      end
      SET_CTRL: begin
        ide_a     = REG_IOCONTROL;
        ide_d_out = ctrl;
        ide_cs    = 1'b1;
        ide_we    = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ide_sector_loader.sv
// Testbench for ide_sector_loader: count table, hand-written corner
// sequences and randomized transfers against a write-list model.
module tb_ide_sector_loader;

  localparam logic [9:0] A_BUF  = 10'h200;
  localparam logic [9:0] A_CTRL = 10'h002;
  localparam logic [9:0] A_POS  = 10'h003;
  localparam logic [9:0] A_TGT  = 10'h005;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] byte_count;
  logic [7:0] ctrl_value;
  logic       busy, done, err;
  logic [7:0] s_data;
  logic       s_valid, s_ready;
  logic [9:0] cpu_a;
  logic [7:0] cpu_d_in, cpu_d_out;
  logic       cpu_cs, cpu_oe, cpu_we, cpu_wait;
  logic [9:0] ide_a;
  logic [7:0] ide_d_out, ide_d_in;
  logic       ide_cs, ide_oe, ide_we, ide_wait;

  ide_sector_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_count(byte_count), .ctrl_value(ctrl_value),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_wait(cpu_wait),
    .ide_a(ide_a), .ide_d_out(ide_d_out), .ide_d_in(ide_d_in),
    .ide_cs(ide_cs), .ide_oe(ide_oe), .ide_we(ide_we),
    .ide_wait(ide_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
    int         cyc;
  } wr_t;

  typedef struct {
    int         cnt;
    bit         bad;
    int         vp;
    int         wp;
    bit         ramp;
    logic [7:0] c;
  } vec_t;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  wr_t  log_q[$];
  logic [7:0] data [1024];
  vec_t tv [10];

  always @(posedge clk) cyc <= cyc + 1;

  // Completed IDE writes and done pulses, outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (ide_cs && ide_we && !ide_wait)
        log_q.push_back('{ide_a, ide_d_out, cyc});
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: every byte to base+i, then iopos, iotarget, iocontrol.
  task automatic cmp_log(input int lb, input int n, input logic [7:0] c);
    logic [9:0] ea[$];
    logic [7:0] ed[$];
    int t;
    t = (n / 2 - 1) % 256;
    for (int i = 0; i < n; i++) begin
      ea.push_back(10'(512 + i));
      ed.push_back(data[i]);
    end
    ea.push_back(A_POS);  ed.push_back(8'h00);
    ea.push_back(A_TGT);  ed.push_back(8'(t));
    ea.push_back(A_CTRL); ed.push_back(c);
    chk("log_len", log_q.size() - lb, ea.size());
    for (int i = 0; i < ea.size() && lb + i < log_q.size(); i++) begin
      chk("wr_a", 32'(log_q[lb+i].a), 32'(ea[i]));
      chk("wr_d", 32'(log_q[lb+i].d), 32'(ed[i]));
    end
  endtask

  task automatic xfer(input int n, input logic [7:0] c, input int vp,
                      input int wp, input bit ramp, input int abort_at,
                      input bit stall);
    int k, lb, db;
    bit got;
    k = 0; got = 0;
    lb = log_q.size(); db = done_cnt;
    for (int i = 0; i < 1024; i++)
      data[i] = ramp ? 8'(i) : 8'($urandom);
    @(posedge clk); #1;
    start = 1; byte_count = 10'(n); ctrl_value = c;
    s_valid = 0; ide_wait = 0;
    for (int it = 0; it < 8000; it++) begin
      @(posedge clk); #1;
      start = (it == 3) || ($urandom_range(0, 19) == 0);
      byte_count = 10'($urandom);
      s_valid = ($urandom_range(0, 99) < vp);
      s_data = data[k & 1023];
      ide_wait = ($urandom_range(0, 99) < wp);
      @(negedge clk);
      if (it == 0) begin
        chk("busy_on", 32'(busy), 1);
        chk("err_clr", 32'(err), 0);
      end
      if (stall) begin
        chk("stall", 32'(cpu_wait), 1);
        chk("no_oe", 32'(ide_oe), 0);
      end
      if (s_valid && s_ready) k++;
      if (done) begin
        got = 1;
        chk("busy_done", 32'(busy), 1);
        break;
      end
      if (abort_at > 0 && k == abort_at) break;
    end
    if (abort_at > 0) return;
    if (!got) chk("timeout", 0, 1);
    @(posedge clk); #1;
    start = 0; s_valid = 0; ide_wait = 0;
    @(negedge clk);
    chk("busy_off", 32'(busy), 0);
    chk("done_1cyc", 32'(done), 0);
    chk("err_ok", 32'(err), 0);
    chk("accepted", k, n);
    chk("done_cnt", done_cnt - db, 1);
    cmp_log(lb, n, c);
    if (wp == 0 && log_q.size() >= lb + n)
      chk("overhead", done_cyc - log_q[lb+n-1].cyc, 4);
    if (vp == 100 && wp == 0 && log_q.size() >= lb + n)
      chk("back2back", log_q[lb+n-1].cyc - log_q[lb].cyc, n - 1);
  endtask

  task automatic bad_start(input int n);
    int lb, db;
    lb = log_q.size(); db = done_cnt;
    @(posedge clk); #1;
    start = 1; byte_count = 10'(n); ide_wait = 0; s_valid = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("bad_err", 32'(err), 1);
    chk("bad_done", 32'(done), 1);
    chk("bad_busy", 32'(busy), 0);
    chk("bad_rdy", 32'(s_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bad_done_off", 32'(done), 0);
    chk("bad_err_hold", 32'(err), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_valid = 0;
    chk("bad_nowr", log_q.size() - lb, 0);
    chk("bad_dcnt", done_cnt - db, 1);
  endtask

  initial begin
    int lb, db, nreg;
    tv[0] = '{7,    1, 0,   0,  0, 8'h00};
    tv[1] = '{0,    1, 0,   0,  0, 8'h00};
    tv[2] = '{514,  1, 0,   0,  0, 8'h00};
    tv[3] = '{512,  0, 100, 0,  1, 8'h01};
    tv[4] = '{1,    1, 0,   0,  0, 8'h00};
    tv[5] = '{2,    0, 50,  0,  0, 8'h3C};
    tv[6] = '{513,  1, 0,   0,  0, 8'h00};
    tv[7] = '{100,  0, 70,  25, 0, 8'hE7};
    tv[8] = '{1022, 1, 0,   0,  0, 8'h00};
    tv[9] = '{510,  0, 100, 0,  0, 8'h55};

    rst = 1; start = 0; byte_count = 0; ctrl_value = 0;
    s_data = 0; s_valid = 0;
    cpu_a = 0; cpu_d_in = 0; cpu_cs = 0; cpu_oe = 0; cpu_we = 0;
    ide_d_in = 0; ide_wait = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    s_valid = 1;
    cpu_a = 10'h2AB; cpu_d_in = 8'hC3;
    cpu_cs = 1; cpu_oe = 1; ide_wait = 1; ide_d_in = 8'h96;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdy", 32'(s_ready), 0);
    chk("pt_a", 32'(ide_a), 32'h2AB);
    chk("pt_d", 32'(ide_d_out), 32'hC3);
    chk("pt_oe", 32'(ide_oe), 1);
    chk("pt_wait", 32'(cpu_wait), 1);
    chk("pt_rd", 32'(cpu_d_out), 32'h96);
    s_valid = 0; cpu_cs = 0; cpu_oe = 0; ide_wait = 0;

    for (int v = 0; v < 10; v++) begin
      if (tv[v].bad) bad_start(tv[v].cnt);
      else xfer(tv[v].cnt, tv[v].c, tv[v].vp, tv[v].wp,
                tv[v].ramp, 0, 0);
    end

    // Two bytes, gapped stream, iotarget write held by wait.
    lb = log_q.size(); db = done_cnt;
    data[0] = 8'hA5; data[1] = 8'h3C;
    @(posedge clk); #1;
    start = 1; byte_count = 10'd2; ctrl_value = 8'h81; s_valid = 0;
    @(posedge clk); #1;
    start = 0; s_valid = 1; s_data = data[0];
    @(posedge clk); #1;
    s_valid = 0;
    @(posedge clk); #1;
    s_valid = 1; s_data = data[1];
    @(posedge clk); #1;
    s_valid = 0;
    @(posedge clk); #1;
    ide_wait = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tgt_a", 32'(ide_a), 32'(A_TGT));
      chk("tgt_d", 32'(ide_d_out), 0);
      chk("tgt_we", 32'({ide_cs, ide_we}), 3);
      @(posedge clk); #1;
    end
    ide_wait = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    cmp_log(lb, 2, 8'h81);
    chk("two_dcnt", done_cnt - db, 1);

    // AVR read stalled during a transfer, then passed through.
    cpu_a = 10'h000; cpu_cs = 1; cpu_oe = 1; cpu_we = 0;
    ide_d_in = 8'h5A;
    xfer(8, 8'h42, 60, 20, 0, 0, 1);
    chk("rd_wait", 32'(cpu_wait), 0);
    chk("rd_oe", 32'(ide_oe), 1);
    chk("rd_cs", 32'(ide_cs), 1);
    chk("rd_a", 32'(ide_a), 0);
    chk("rd_d", 32'(cpu_d_out), 32'h5A);
    ide_wait = 1;
    #1 chk("rd_wait2", 32'(cpu_wait), 1);
    ide_wait = 0; cpu_cs = 0; cpu_oe = 0;

    // Reset after 100 bytes.
    lb = log_q.size(); db = done_cnt;
    xfer(300, 8'h99, 100, 0, 0, 100, 0);
    @(posedge clk); #1;
    rst = 1; s_valid = 1; start = 0; ide_wait = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rdy", 32'(s_ready), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_len", log_q.size() - lb, 100);
    nreg = 0;
    for (int i = lb; i < log_q.size(); i++)
      if (log_q[i].a < A_BUF) nreg++;
    chk("ab_noreg", nreg, 0);
    chk("ab_dcnt", done_cnt - db, 0);
    s_valid = 0;
    cpu_a = 10'h123; cpu_d_in = 8'h77; cpu_cs = 1; cpu_we = 1;
    #1;
    chk("ab_pt_a", 32'(ide_a), 32'h123);
    chk("ab_pt_d", 32'(ide_d_out), 32'h77);
    chk("ab_pt_we", 32'({ide_cs, ide_we}), 3);
    @(posedge clk); #1;
    cpu_cs = 0; cpu_we = 0;

    for (int r = 0; r < 8; r++)
      xfer(2 * $urandom_range(1, 100), 8'($urandom),
           $urandom_range(30, 100), $urandom_range(0, 40), 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
